// File: rtl/axi_line_adapter.sv
// Cache-side request to AXI4 master bridge: single-beat accesses or full cache-line INCR
// bursts, one transaction outstanding, bus errors reported back with the completion.
package ariane_axi;
    typedef enum logic { SINGLE_REQ = 1'b0, CACHE_LINE_REQ = 1'b1 } ad_req_t;

    typedef struct packed {
        logic [4:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } w_chan_t;

    typedef struct packed {
        logic [4:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [4:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } ar_chan_t;

    typedef struct packed {
        logic [4:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_line_adapter #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CACHELINE_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned ID_WIDTH        = 5,
    parameter type         axi_req_t       = ariane_axi::req_t,
    parameter type         axi_resp_t      = ariane_axi::resp_t
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_i,
    input  ariane_axi::ad_req_t            type_i,
    input  logic                           we_i,
    input  logic [ADDR_WIDTH-1:0]          addr_i,
    input  logic [2:0]                     size_i,
    input  logic [CACHELINE_WIDTH/8-1:0]   be_i,
    input  logic [CACHELINE_WIDTH-1:0]     wdata_i,
    input  logic [ID_WIDTH-1:0]            id_i,
    output logic                           gnt_o,
    output logic                           valid_o,
    output logic [CACHELINE_WIDTH-1:0]     rdata_o,
    output logic                           err_o,
    output logic [ID_WIDTH-1:0]            id_o,
    output axi_req_t                       axi_req_o,
    input  axi_resp_t                      axi_resp_i
);
    localparam int unsigned BEATS  = CACHELINE_WIDTH / DATA_WIDTH;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [2:0]  LINE_SIZE = 3'($clog2(STRB_W));
    localparam logic [7:0]  LINE_LEN  = 8'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(CACHELINE_WIDTH / 8 - 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_DATA, WR_RESP, RD_ADDR, RD_DATA
    } state_e;

    state_e                         state_q;
    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [2:0]                     size_q;
    logic [7:0]                     len_q;
    logic [CACHELINE_WIDTH/8-1:0]   be_q;
    logic [CACHELINE_WIDTH-1:0]     wdata_q;
    logic [ID_WIDTH-1:0]            id_q;
    logic [8:0]                     cnt_q;
    logic                           err_acc_q;
    logic                           aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
    logic                           valid_q, err_q;
    logic [CACHELINE_WIDTH-1:0]     rdata_q;
    logic [ID_WIDTH-1:0]            id_out_q;

    logic [IDX_W-1:0] beat_idx;
    logic             w_last, aw_hs, w_hs, in_range, early_last;
    logic             unused_resp;

    assign beat_idx    = cnt_q[IDX_W-1:0];
    assign w_last      = (cnt_q == {1'b0, len_q});
    assign aw_hs       = aw_valid_q & axi_resp_i.aw_ready;
    assign w_hs        = w_valid_q & axi_resp_i.w_ready;
    // Beats past len are outside the line; they are dropped and flagged as an error.
    assign in_range    = (cnt_q <= {1'b0, len_q});
    assign early_last  = (cnt_q < {1'b0, len_q});
    assign unused_resp = ^axi_resp_i;

    assign gnt_o   = req_i && (state_q == IDLE);
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign id_o    = id_out_q;

    // NOTE: every field gets a default first so no path through the block infers a latch.
    always_comb begin
        axi_req_o           = '0;
        axi_req_o.aw.id     = id_q;
        axi_req_o.aw.addr   = addr_q;
        axi_req_o.aw.len    = len_q;
        axi_req_o.aw.size   = size_q;
        axi_req_o.aw.burst  = 2'b01;
        axi_req_o.aw.cache  = 4'b0010;
        axi_req_o.aw_valid  = aw_valid_q;
        axi_req_o.w.data    = wdata_q[beat_idx*DATA_WIDTH +: DATA_WIDTH];
        axi_req_o.w.strb    = be_q[beat_idx*STRB_W +: STRB_W];
        axi_req_o.w.last    = w_last;
        axi_req_o.w_valid   = w_valid_q;
        axi_req_o.b_ready   = b_ready_q;
        axi_req_o.ar.id     = id_q;
        axi_req_o.ar.addr   = addr_q;
        axi_req_o.ar.len    = len_q;
        axi_req_o.ar.size   = size_q;
        axi_req_o.ar.burst  = 2'b01;
        axi_req_o.ar.cache  = 4'b0010;
        axi_req_o.ar_valid  = ar_valid_q;
        axi_req_o.r_ready   = r_ready_q;
    end

    // NOTE: state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            len_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            err_acc_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            id_out_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: if (req_i) begin
                    id_q      <= id_i;
                    be_q      <= be_i;
                    wdata_q   <= wdata_i;
                    cnt_q     <= '0;
                    err_acc_q <= 1'b0;
                    if (type_i == ariane_axi::CACHE_LINE_REQ) begin
                        addr_q <= addr_i & LINE_MASK;
                        len_q  <= LINE_LEN;
                        size_q <= LINE_SIZE;
                    end else begin
                        addr_q <= addr_i;
                        len_q  <= '0;
                        size_q <= size_i;
                    end
                    if (we_i) begin
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        state_q    <= WR_ADDR_DATA;
                    end else begin
                        ar_valid_q <= 1'b1;
                        state_q    <= RD_ADDR;
                    end
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) aw_valid_q <= 1'b0;
                    if (w_hs) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (w_last) w_valid_q <= 1'b0;
                    end
                    if ((aw_hs || !aw_valid_q) && ((w_hs && w_last) || !w_valid_q)) begin
                        b_ready_q <= 1'b1;
                        state_q   <= WR_RESP;
                    end else if (aw_hs || !aw_valid_q) begin
                        state_q <= WR_DATA;
                    end
                end
                WR_DATA: if (w_hs) begin
                    cnt_q <= cnt_q + 9'd1;
                    if (w_last) begin
                        w_valid_q <= 1'b0;
                        b_ready_q <= 1'b1;
                        state_q   <= WR_RESP;
                    end
                end
                WR_RESP: if (axi_resp_i.b_valid) begin
                    b_ready_q <= 1'b0;
                    valid_q   <= 1'b1;
                    err_q     <= axi_resp_i.b.resp[1];
                    id_out_q  <= id_q;
                    state_q   <= IDLE;
                end
                RD_ADDR: if (axi_resp_i.ar_ready) begin
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b1;
                    state_q    <= RD_DATA;
                end
                RD_DATA: if (axi_resp_i.r_valid) begin
                    if (in_range) begin
                        rdata_q[beat_idx*DATA_WIDTH +: DATA_WIDTH] <= axi_resp_i.r.data;
                        cnt_q <= cnt_q + 9'd1;
                    end
                    if (axi_resp_i.r.last) begin
                        r_ready_q <= 1'b0;
                        valid_q   <= 1'b1;
                        err_q     <= err_acc_q | axi_resp_i.r.resp[1] | early_last | !in_range;
                        id_out_q  <= id_q;
                        state_q   <= IDLE;
                    end else begin
                        err_acc_q <= err_acc_q | axi_resp_i.r.resp[1] | !in_range;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_line_adapter.sv
// Directed bench for axi_line_adapter: 64/128 instance driven from a vector table and
// hand sequences, plus a 32/256 instance for the eight-beat stalled line write.
module tb_axi_line_adapter;
    import ariane_axi::*;

    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; logic [0:0] user; } w32_t;
    typedef struct packed { logic [4:0] id; logic [31:0] data; logic [1:0] resp; logic last; logic [0:0] user; } r32_t;
    typedef struct packed {
        aw_chan_t aw; logic aw_valid; w32_t w; logic w_valid; logic b_ready;
        ar_chan_t ar; logic ar_valid; logic r_ready;
    } req32_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_t b; logic r_valid; r32_t r;
    } resp32_t;

    typedef struct {
        logic        we;
        ad_req_t     typ;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [4:0]  id;
        logic [1:0]  resp;
        logic [63:0] exp_addr;
        logic [7:0]  exp_len;
        logic [2:0]  exp_size;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    // 64-bit data / 128-bit line instance
    logic         req, we, gnt, valid, err;
    ad_req_t      typ;
    logic [63:0]  addr;
    logic [2:0]   size;
    logic [15:0]  be;
    logic [127:0] wdata, rdata, exp_rdata;
    logic [4:0]   id, id_out;
    req_t         axi_req;
    resp_t        axi_resp;

    // 32-bit data / 256-bit line instance
    logic         l_req, l_we, l_gnt, l_valid, l_err;
    ad_req_t      l_typ;
    logic [63:0]  l_addr;
    logic [2:0]   l_size;
    logic [31:0]  l_be;
    logic [255:0] l_wdata, l_rdata;
    logic [4:0]   l_id, l_id_out;
    req32_t       l_axi_req;
    resp32_t      l_axi_resp;

    axi_line_adapter dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .type_i(typ), .we_i(we), .addr_i(addr),
        .size_i(size), .be_i(be), .wdata_i(wdata), .id_i(id), .gnt_o(gnt), .valid_o(valid),
        .rdata_o(rdata), .err_o(err), .id_o(id_out), .axi_req_o(axi_req), .axi_resp_i(axi_resp)
    );

    axi_line_adapter #(
        .DATA_WIDTH(32), .CACHELINE_WIDTH(256), .ADDR_WIDTH(64), .ID_WIDTH(5),
        .axi_req_t(req32_t), .axi_resp_t(resp32_t)
    ) dut_l (
        .clk_i(clk), .rst_ni(rst_n), .req_i(l_req), .type_i(l_typ), .we_i(l_we), .addr_i(l_addr),
        .size_i(l_size), .be_i(l_be), .wdata_i(l_wdata), .id_i(l_id), .gnt_o(l_gnt), .valid_o(l_valid),
        .rdata_o(l_rdata), .err_o(l_err), .id_o(l_id_out), .axi_req_o(l_axi_req), .axi_resp_i(l_axi_resp)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int seed, input int k);
        logic [63:0] base;
        base = k[0] ? 64'hBBBB_BBBB_BBBB_BBBB : 64'hAAAA_AAAA_AAAA_AAAA;
        return base ^ (64'(seed) << 8);
    endfunction

    // Called at a falling edge in IDLE; returns at the falling edge after the grant edge.
    task automatic issue_a(input logic w, input ad_req_t t, input logic [63:0] a,
                           input logic [2:0] s, input logic [4:0] i);
        req = 1'b1; we = w; typ = t; addr = a; size = s; id = i;
        #1 check("gnt", gnt, 1'b1);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic read_a(input logic [63:0] exp_addr, input logic [7:0] exp_len,
                          input logic [2:0] exp_size, input logic [4:0] exp_id,
                          input int nbeats, input int last_at, input int err_beat,
                          input logic [1:0] base_resp, input int seed);
        check("ar_valid", axi_req.ar_valid, 1'b1);
        check("ar_addr", axi_req.ar.addr, exp_addr);
        check("ar_len", axi_req.ar.len, exp_len);
        check("ar_size", axi_req.ar.size, exp_size);
        check("ar_id", axi_req.ar.id, exp_id);
        check("ar_burst", {axi_req.ar.burst, axi_req.ar.cache}, 6'b01_0010);
        axi_resp.ar_ready = 1'b1;
        @(negedge clk);
        axi_resp.ar_ready = 1'b0;
        check("ar_valid_drop", axi_req.ar_valid, 1'b0);
        check("r_ready", axi_req.r_ready, 1'b1);
        for (int k = 0; k < nbeats; k++) begin
            axi_resp.r_valid  = 1'b1;
            axi_resp.r.id     = exp_id;
            axi_resp.r.data   = beat_data(seed, k);
            axi_resp.r.resp   = (k == err_beat) ? 2'b10 : base_resp;
            axi_resp.r.last   = (k == last_at);
            if (k <= int'(exp_len)) exp_rdata[k*64 +: 64] = beat_data(seed, k);
            @(negedge clk);
        end
        axi_resp.r_valid = 1'b0;
        axi_resp.r.last  = 1'b0;
    endtask

    task automatic write_a(input logic [63:0] exp_addr, input logic [7:0] exp_len,
                           input logic [2:0] exp_size, input logic [4:0] exp_id,
                           input int aw_delay, input logic [1:0] bresp,
                           output int aw_cyc, output int last_w_cyc);
        int   cyc = 0;
        int   beats = 0;
        logic aw_done = 1'b0;
        aw_cyc = -1;
        last_w_cyc = -1;
        check("aw_valid", axi_req.aw_valid, 1'b1);
        check("w_valid", axi_req.w_valid, 1'b1);
        check("aw_addr", axi_req.aw.addr, exp_addr);
        check("aw_len", axi_req.aw.len, exp_len);
        check("aw_size", axi_req.aw.size, exp_size);
        check("aw_id", axi_req.aw.id, exp_id);
        while ((!aw_done || beats <= int'(exp_len)) && cyc < 50) begin
            axi_resp.aw_ready = (cyc >= aw_delay);
            axi_resp.w_ready  = 1'b1;
            if (axi_req.aw_valid && !aw_done) begin
                if (axi_resp.aw_ready) begin aw_done = 1'b1; aw_cyc = cyc; end
            end
            if (axi_req.w_valid) begin
                check("w_data", axi_req.w.data, wdata[beats*64 +: 64]);
                check("w_strb", axi_req.w.strb, be[beats*8 +: 8]);
                check("w_last", axi_req.w.last, beats == int'(exp_len));
                last_w_cyc = cyc;
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        axi_resp.aw_ready = 1'b0;
        axi_resp.w_ready  = 1'b0;
        check("w_beats", beats, int'(exp_len) + 1);
        check("aw_done", aw_done, 1'b1);
        check("b_ready", axi_req.b_ready, 1'b1);
        check("wr_valids_drop", {axi_req.aw_valid, axi_req.w_valid}, 2'b00);
        axi_resp.b_valid = 1'b1;
        axi_resp.b.resp  = bresp;
        axi_resp.b.id    = exp_id;
        @(negedge clk);
        axi_resp.b_valid = 1'b0;
    endtask

    task automatic done_a(input logic exp_err, input logic [4:0] exp_id);
        check("valid_o", valid, 1'b1);
        check("err_o", err, exp_err);
        check("id_o", id_out, exp_id);
        check("rdata_o", rdata, exp_rdata);
        @(negedge clk);
        check("valid_pulse", valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   awc, lwc;
        vecs[0] = '{1'b0, CACHE_LINE_REQ, 64'h1008, 3'd0, 5'h01, 2'b00, 64'h1000, 8'd1, 3'd3, 1'b0};
        vecs[1] = '{1'b0, SINGLE_REQ, 64'h2004, 3'd2, 5'h02, 2'b00, 64'h2004, 8'd0, 3'd2, 1'b0};
        vecs[2] = '{1'b1, CACHE_LINE_REQ, 64'h30F8, 3'd0, 5'h03, 2'b00, 64'h30F0, 8'd1, 3'd3, 1'b0};
        vecs[3] = '{1'b1, SINGLE_REQ, 64'h4001, 3'd0, 5'h04, 2'b10, 64'h4001, 8'd0, 3'd0, 1'b1};
        vecs[4] = '{1'b0, CACHE_LINE_REQ, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 5'h1F, 2'b11,
                    64'hFFFF_FFFF_FFFF_FFF0, 8'd1, 3'd3, 1'b1};
        vecs[5] = '{1'b1, SINGLE_REQ, 64'h0, 3'd3, 5'h00, 2'b01, 64'h0, 8'd0, 3'd3, 1'b0};

        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; typ = SINGLE_REQ; addr = '0; size = '0; be = '0; wdata = '0; id = '0;
        axi_resp = '0;
        l_req = 1'b0; l_we = 1'b0; l_typ = SINGLE_REQ; l_addr = '0; l_size = '0; l_be = '0;
        l_wdata = '0; l_id = '0; l_axi_resp = '0;
        exp_rdata = '0;

        #12;
        check("rst_outputs", {gnt, valid, err, id_out}, '0);
        check("rst_rdata", rdata, '0);
        check("rst_axi", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                          axi_req.ar_valid, axi_req.r_ready}, 5'b0);
        check("rst_l_valid", {l_valid, l_axi_req.aw_valid, l_axi_req.w_valid}, 3'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            be    = 16'hFFFF ^ 16'(i * 16'h0101);
            wdata = {64'hFEED_0000_0000_0001 + 64'(i), 64'hCAFE_0000_0000_0000 + 64'(i)};
            issue_a(vecs[i].we, vecs[i].typ, vecs[i].addr, vecs[i].size, vecs[i].id);
            if (vecs[i].we)
                write_a(vecs[i].exp_addr, vecs[i].exp_len, vecs[i].exp_size, vecs[i].id, 0,
                        vecs[i].resp, awc, lwc);
            else
                read_a(vecs[i].exp_addr, vecs[i].exp_len, vecs[i].exp_size, vecs[i].id,
                       int'(vecs[i].exp_len) + 1, int'(vecs[i].exp_len), -1, vecs[i].resp, i);
            done_a(vecs[i].exp_err, vecs[i].id);
        end

        // Single write whose W beat completes while AW is still stalled
        be = 16'h000F;
        wdata = {64'h0, 64'h1122_3344_5566_7788};
        issue_a(1'b1, SINGLE_REQ, 64'h2004, 3'd2, 5'h09);
        write_a(64'h2004, 8'd0, 3'd2, 5'h09, 3, 2'b00, awc, lwc);
        check("w_before_aw", (lwc >= 0) && (lwc < awc), 1'b1);
        done_a(1'b0, 5'h09);

        // SLVERR on the second beat only
        issue_a(1'b0, CACHE_LINE_REQ, 64'h7010, 3'd0, 5'h13);
        read_a(64'h7010, 8'd1, 3'd3, 5'h13, 2, 1, 1, 2'b00, 20);
        done_a(1'b1, 5'h13);

        // r.last on beat 0 of a line: slice 1 keeps the previous contents
        issue_a(1'b0, CACHE_LINE_REQ, 64'h8000, 3'd0, 5'h0C);
        read_a(64'h8000, 8'd1, 3'd3, 5'h0C, 1, 0, -1, 2'b00, 21);
        done_a(1'b1, 5'h0C);
        req = 1'b1; we = 1'b0; typ = SINGLE_REQ;
        #1 check("idle_after_early_last", gnt, 1'b1);
        req = 1'b0;
        @(negedge clk);

        // Extra beat past the line before r.last
        issue_a(1'b0, CACHE_LINE_REQ, 64'h9000, 3'd0, 5'h0D);
        read_a(64'h9000, 8'd1, 3'd3, 5'h0D, 3, 2, -1, 2'b00, 22);
        done_a(1'b1, 5'h0D);

        // Back-to-back: grant in the cycle valid_o is high
        issue_a(1'b0, SINGLE_REQ, 64'h6000, 3'd3, 5'h05);
        read_a(64'h6000, 8'd0, 3'd3, 5'h05, 1, 0, -1, 2'b00, 23);
        req = 1'b1; we = 1'b0; typ = SINGLE_REQ; addr = 64'h6008; size = 3'd3; id = 5'h06;
        #1 check("b2b_valid", valid, 1'b1);
        check("b2b_gnt", gnt, 1'b1);
        @(negedge clk);
        req = 1'b0;
        read_a(64'h6008, 8'd0, 3'd3, 5'h06, 1, 0, -1, 2'b00, 24);
        done_a(1'b0, 5'h06);

        // Asynchronous reset while in WR_DATA
        issue_a(1'b1, CACHE_LINE_REQ, 64'h5000, 3'd0, 5'h07);
        axi_resp.aw_ready = 1'b1;
        axi_resp.w_ready  = 1'b0;
        @(negedge clk);
        axi_resp.aw_ready = 1'b0;
        check("wr_data_state", {axi_req.aw_valid, axi_req.w_valid}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_axi", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready,
                                axi_req.ar_valid, axi_req.r_ready}, 5'b0);
        check("async_rst_valid", valid, 1'b0);
        exp_rdata = '0;
        check("async_rst_rdata", rdata, exp_rdata);
        @(negedge clk);
        rst_n = 1'b1;
        issue_a(1'b0, SINGLE_REQ, 64'hA000, 3'd3, 5'h0E);
        read_a(64'hA000, 8'd0, 3'd3, 5'h0E, 1, 0, -1, 2'b00, 25);
        done_a(1'b0, 5'h0E);

        // 32/256 instance: eight-beat line write with random W stalls, request held high
        begin
            int   beats = 0;
            int   cyc = 0;
            logic aw_done = 1'b0;
            logic gnt_seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                l_wdata[k*32 +: 32] = 32'hC0DE_0000 + 32'(k * 32'h1111);
                l_be[k*4 +: 4]      = 4'(1 << (k % 4)) | 4'h8;
            end
            l_req = 1'b1; l_we = 1'b1; l_typ = CACHE_LINE_REQ; l_addr = 64'h8000_0024; l_id = 5'h0A;
            #1 check("l_gnt", l_gnt, 1'b1);
            @(negedge clk);
            check("l_aw_addr", l_axi_req.aw.addr, 64'h8000_0020);
            check("l_aw_len", l_axi_req.aw.len, 8'd7);
            check("l_aw_size", l_axi_req.aw.size, 3'd2);
            while ((!aw_done || beats < 8) && cyc < 200) begin
                if (l_gnt) gnt_seen = 1'b1;
                l_axi_resp.aw_ready = 1'b1;
                l_axi_resp.w_ready  = 1'($urandom_range(0, 1));
                if (l_axi_req.aw_valid) aw_done = 1'b1;
                if (l_axi_req.w_valid && l_axi_resp.w_ready) begin
                    check("l_w_data", l_axi_req.w.data, l_wdata[beats*32 +: 32]);
                    check("l_w_strb", l_axi_req.w.strb, l_be[beats*4 +: 4]);
                    check("l_w_last", l_axi_req.w.last, beats == 7);
                    beats++;
                end
                @(negedge clk);
                cyc++;
            end
            l_axi_resp.aw_ready = 1'b0;
            l_axi_resp.w_ready  = 1'b0;
            check("l_w_beats", beats, 8);
            check("l_b_ready", l_axi_req.b_ready, 1'b1);
            if (l_gnt) gnt_seen = 1'b1;
            l_axi_resp.b_valid = 1'b1;
            l_axi_resp.b.resp  = 2'b00;
            @(negedge clk);
            l_axi_resp.b_valid = 1'b0;
            check("l_no_gnt_while_busy", gnt_seen, 1'b0);
            check("l_valid_o", l_valid, 1'b1);
            check("l_err_o", l_err, 1'b0);
            check("l_id_o", l_id_out, 5'h0A);
            check("l_gnt_at_done", l_gnt, 1'b1);
            l_req = 1'b0;
            @(negedge clk);
            check("l_valid_pulse", l_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_line_adapter.md
Name: axi_line_adapter

Overview:
Parametrised bridge from the cache-side request interface to a single AXI4 master port. It issues either single-beat accesses or full cache-line INCR bursts, selected per request by ariane_axi::ad_req_t. Unlike the fixed 64-bit/two-beat adapter, data width, line width, ID width and the AXI struct types are all parameters, and bus errors are reported back to the requester. It sits between the cache subsystem and the SoC AXI crossbar, with exactly one transaction outstanding.

Parameters:
DATA_WIDTH, 64, AXI data width in bits (power of two, >= 32)
CACHELINE_WIDTH, 128, line width in bits; integer multiple of DATA_WIDTH; BEATS = CACHELINE_WIDTH/DATA_WIDTH, 1..256
ADDR_WIDTH, 64, AXI address width
ID_WIDTH, 5, AXI ID width
axi_req_t, ariane_axi::req_t, AXI request struct type
axi_resp_t, ariane_axi::resp_t, AXI response struct type

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
req_i  in  1  request valid
type_i  in  1  ariane_axi::ad_req_t: SINGLE_REQ or CACHE_LINE_REQ
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_WIDTH  byte address
size_i  in  3  AXI size, single requests only
be_i  in  CACHELINE_WIDTH/8  byte enables; beat k uses slice k
wdata_i  in  CACHELINE_WIDTH  write data; beat k uses slice k
id_i  in  ID_WIDTH  transaction ID
gnt_o  out  1  request accepted
valid_o  out  1  one-cycle completion pulse
rdata_o  out  CACHELINE_WIDTH  read data; single reads in slice 0
err_o  out  1  qualified by valid_o: any beat returned SLVERR/DECERR
id_o  out  ID_WIDTH  ID of the completed transaction
axi_req_o  out  axi_req_t  AXI master request
axi_resp_i  in  axi_resp_t  AXI master response

Behaviour:
- States: IDLE, WR_ADDR_DATA, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- Reset: state IDLE; gnt_o, valid_o, err_o = 0; rdata_o, id_o = 0; all AXI valid/ready = 0. Asynchronous reset mid-transaction drops every valid/ready immediately. Only legal under global reset.
- IDLE: gnt_o = req_i, combinational. On a grant, register type, address, size, be, wdata and id; clear the beat counter and the error flag. Go to WR_ADDR_DATA if we_i, else RD_ADDR. gnt_o is 0 in every other state.
- Burst fields:
  - SINGLE: len = 0, addr = addr_i, size = size_i.
  - LINE: len = BEATS-1; addr = addr_i aligned down to CACHELINE_WIDTH/8; size = log2(DATA_WIDTH/8).
  - Both: burst INCR, cache 4'b0010, prot, lock, qos, region, atop and user = 0. aw.id and ar.id = captured id.
- WR_ADDR_DATA: aw_valid and w_valid are asserted in the same cycle, and their handshakes complete independently. aw_valid drops after the AW handshake. Each W handshake advances the beat counter. w.last = (counter == len). Once AW is done and the last W is done, go to WR_RESP. If AW is done first, go to WR_DATA.
- WR_DATA: w_valid = 1 until the last-beat handshake, then go to WR_RESP.
- WR_RESP: b_ready = 1. On b_valid: valid_o pulses next cycle, err_o = resp[1], id_o = captured id, then IDLE.
- RD_ADDR: ar_valid = 1; on ar_ready go to RD_DATA. ar_valid stays stable until the handshake.
- RD_DATA: r_ready = 1. Each beat's data is written to rdata_o slice [counter] and the counter increments. err_o accumulates the OR of resp[1] over all beats.
- Read completion: on r.last, valid_o pulses next cycle, then IDLE.
- Early r.last (counter < len) also terminates and forces err_o = 1. Unfilled rdata_o slices keep their previous values.
- Extra beats after BEATS without r.last: ignored for data, err_o = 1, and the FSM keeps waiting for r.last.
- rdata_o, err_o and id_o hold their values until the next completion.
- Latency with an always-ready slave:
  - Read: grant, AR at +1, first R at +2, valid_o one cycle after the last R.
  - Write: grant, AW+W0 at +1, B one cycle after the last W, valid_o one cycle after B.
- Back-to-back: a new grant is possible in the cycle valid_o is high.

Test Plan:
- DATA 64, LINE 128; LINE read addr 0x1008, slave returns 0xAAAA..., then 0xBBBB... with last -> ar.addr 0x1000, len 1, size 3; valid_o once; rdata_o = {0xBBBB..., 0xAAAA...}; err_o = 0.
- SINGLE write addr 0x2004, size 2, be 0x0F, aw_ready delayed 3 cycles, w_ready 1 -> W beat completes before AW; aw.len 0; w.last 1; exactly one valid_o after B; err_o = 0.
- LINE write with DATA 32, LINE 256 (8 beats), random w_ready stalls -> 8 W handshakes in slice order; last only on beat 7; no gnt_o until valid_o.
- LINE read with beat 1 resp SLVERR -> err_o = 1 with valid_o; id_o = request ID 0x13.
- LINE read, slave asserts r.last on beat 0 -> valid_o, err_o = 1, FSM back in IDLE.
- Reset asserted during WR_DATA -> all AXI valids and valid_o drop asynchronously; after release, a new request is granted in the first cycle.
